// File: rtl/shift_unit_arbiter.sv
// Two-port round-robin arbiter in front of one 32-bit shifter (SLL/SRL/SRA),
// with a one-entry registered result stage and valid/ready on every port.
module shift_unit_arbiter #(
    parameter int TAG_W      = 4,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [1:0]       req0_op_i,
    input  logic [31:0]      req0_a_i,
    input  logic [4:0]       req0_shamt_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [1:0]       req1_op_i,
    input  logic [31:0]      req1_a_i,
    input  logic [4:0]       req1_shamt_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_id_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o
);

    logic             prio;
    logic             can_accept;
    logic             gnt0;
    logic             gnt1;
    logic             xfer;
    logic [1:0]       sel_op;
    logic [31:0]      sel_a;
    logic [4:0]       sel_shamt;
    logic [TAG_W-1:0] sel_tag;
    logic [31:0]      result;

    assign can_accept = !rsp_valid_o || rsp_ready_i;

    // prio==1 means requester 1 wins a tie
    assign gnt1 = req1_valid_i && (!req0_valid_i || prio);
    assign gnt0 = req0_valid_i && !gnt1;

    // Gated by rst_ni because can_accept is already true while in reset
    assign req0_ready_o = rst_ni && can_accept && gnt0;
    assign req1_ready_o = rst_ni && can_accept && gnt1;
    assign xfer         = req0_ready_o || req1_ready_o;

    always_comb begin
        sel_op    = req0_op_i;
        sel_a     = req0_a_i;
        sel_shamt = req0_shamt_i;
        sel_tag   = req0_tag_i;
        if (gnt1) begin
            sel_op    = req1_op_i;
            sel_a     = req1_a_i;
            sel_shamt = req1_shamt_i;
            sel_tag   = req1_tag_i;
        end
    end

    always_comb begin
        result = 32'h0;
        case (sel_op)
            2'b00:   result = sel_a << sel_shamt;
            2'b01:   result = sel_a >> sel_shamt;
            2'b10:   result = $signed(sel_a) >>> sel_shamt;
            default: result = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 32'h0;
            rsp_id_o    <= 1'b0;
            rsp_tag_o   <= '0;
            rsp_err_o   <= 1'b0;
            prio        <= RESET_PRIO;
        end else if (xfer) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= result;
            rsp_id_o    <= gnt1;
            rsp_tag_o   <= sel_tag;
            rsp_err_o   <= (sel_op == 2'b11);
            prio        <= !gnt1;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: arithmetic reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_shift_unit_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [1:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_a_i, req1_a_i;
    logic [4:0]  req0_shamt_i, req1_shamt_i;
    logic [3:0]  req0_tag_i, req1_tag_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_id_o;
    logic [3:0]  rsp_tag_o;
    logic        rsp_err_o;

    int checks = 0;
    int errors = 0;

    shift_unit_arbiter #(.TAG_W(4), .RESET_PRIO(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_op_i(req0_op_i), .req0_a_i(req0_a_i),
        .req0_shamt_i(req0_shamt_i), .req0_tag_i(req0_tag_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_op_i(req1_op_i), .req1_a_i(req1_a_i),
        .req1_shamt_i(req1_shamt_i), .req1_tag_i(req1_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
        .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Shift result by plain arithmetic: powers of two and fill masks
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] sh);
        longint unsigned p, av, fill;
        p  = 64'd1 << sh;
        av = {32'h0, a};
        fill = 64'h1_0000_0000 - (64'h1_0000_0000 / p);
        case (op)
            2'd0:    return 32'((av * p) % 64'h1_0000_0000);
            2'd1:    return 32'(av / p);
            2'd2:    return 32'((av / p) + (a[31] ? fill : 64'd0));
            default: return 32'h0;
        endcase
    endfunction

    // Model: who wins now (-1 none), from the arbitration rules
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_id;
    logic [3:0]  m_tag;
    logic        m_err;
    int          m_prio;

    function automatic int winner();
        int w;
        w = -1;
        if (req0_valid_i && req1_valid_i) w = m_prio;
        else if (req0_valid_i) w = 0;
        else if (req1_valid_i) w = 1;
        if (m_valid && !rsp_ready_i) w = -1;
        return w;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        int w;
        if (!rst_ni) begin
            m_valid = 1'b0; m_data = 32'h0; m_id = 1'b0; m_tag = 4'h0; m_err = 1'b0;
            m_prio  = 0;
        end else begin
            w = winner();
            if (w == 0) begin
                m_valid = 1'b1; m_id = 1'b0; m_tag = req0_tag_i;
                m_data = ref_shift(req0_op_i, req0_a_i, req0_shamt_i);
                m_err = (req0_op_i == 2'd3); m_prio = 1;
            end else if (w == 1) begin
                m_valid = 1'b1; m_id = 1'b1; m_tag = req1_tag_i;
                m_data = ref_shift(req1_op_i, req1_a_i, req1_shamt_i);
                m_err = (req1_op_i == 2'd3); m_prio = 0;
            end else if (rsp_ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        int w;
        if (!rst_ni) begin
            chk("rst_ready0", 32'(req0_ready_o), 32'h0);
            chk("rst_ready1", 32'(req1_ready_o), 32'h0);
            chk("rst_valid", 32'(rsp_valid_o), 32'h0);
            chk("rst_data", rsp_data_o, 32'h0);
        end else begin
            w = winner();
            chk("m_ready0", 32'(req0_ready_o), 32'(w == 0));
            chk("m_ready1", 32'(req1_ready_o), 32'(w == 1));
            chk("m_valid", 32'(rsp_valid_o), 32'(m_valid));
            if (m_valid) begin
                chk("m_data", rsp_data_o, m_data);
                chk("m_id", 32'(rsp_id_o), 32'(m_id));
                chk("m_tag", 32'(rsp_tag_o), 32'(m_tag));
                chk("m_err", 32'(rsp_err_o), 32'(m_err));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] sh, input logic [3:0] tag);
        req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_shamt_i = sh; req0_tag_i = tag;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] sh, input logic [3:0] tag);
        req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_shamt_i = sh; req1_tag_i = tag;
    endtask

    task automatic single0(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [4:0] sh, input logic [31:0] exp);
        set0(1'b1, op, a, sh, 4'h1);
        step();
        req0_valid_i = 1'b0;
        chk({name, "_valid"}, 32'(rsp_valid_o), 32'h1);
        chk({name, "_data"}, rsp_data_o, exp);
        chk({name, "_id"}, 32'(rsp_id_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        rsp_ready_i = 1'b1;
        set0(1'b0, 2'd0, 32'h0, 5'd0, 4'h0);
        set1(1'b0, 2'd0, 32'h0, 5'd0, 4'h0);
        #1;
        chk("reset_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_tag", 32'(rsp_tag_o), 32'h0);
        step(); step();
        rst_ni = 1'b1;

        // Contention: strict alternation starting at requester 0
        set0(1'b1, 2'd0, 32'h1, 5'd0, 4'hA);
        set1(1'b1, 2'd1, 32'h2, 5'd1, 4'h5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_valid", 32'(rsp_valid_o), 32'h1);
            chk("cont_id", 32'(rsp_id_o), 32'(i % 2));
            chk("cont_tag", 32'(rsp_tag_o), (i % 2) ? 32'h5 : 32'hA);
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        step();
        chk("drain_valid", 32'(rsp_valid_o), 32'h0);

        single0("sra4", 2'd2, 32'h8000_0000, 5'd4, 32'hF800_0000);
        single0("srl4", 2'd1, 32'h8000_0000, 5'd4, 32'h0800_0000);
        single0("sll31", 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000);
        single0("sra31", 2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
        single0("sra31n", 2'd2, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF);
        single0("sll0", 2'd0, 32'h1234_5678, 5'd0, 32'h1234_5678);
        single0("srl0", 2'd1, 32'h1234_5678, 5'd0, 32'h1234_5678);
        single0("sra0", 2'd2, 32'h1234_5678, 5'd0, 32'h1234_5678);

        // Reserved op from requester 1, then a normal one
        set1(1'b1, 2'd3, 32'hFFFF_FFFF, 5'd3, 4'h7);
        step();
        chk("rsv_data", rsp_data_o, 32'h0);
        chk("rsv_err", 32'(rsp_err_o), 32'h1);
        chk("rsv_id", 32'(rsp_id_o), 32'h1);
        set1(1'b1, 2'd0, 32'h1, 5'd1, 4'h8);
        step();
        req1_valid_i = 1'b0;
        chk("after_rsv_err", 32'(rsp_err_o), 32'h0);
        chk("after_rsv_data", rsp_data_o, 32'h2);

        // Backpressure with req1 waiting
        set0(1'b1, 2'd2, 32'h8000_0000, 5'd4, 4'h2);
        step();
        req0_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        set1(1'b1, 2'd1, 32'h0000_00F0, 5'd4, 4'h3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_data", rsp_data_o, 32'hF800_0000);
            chk("bp_id", 32'(rsp_id_o), 32'h0);
            chk("bp_ready1", 32'(req1_ready_o), 32'h0);
            step();
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_release_ready1", 32'(req1_ready_o), 32'h1);
        step();
        req1_valid_i = 1'b0;
        chk("bp_new_valid", 32'(rsp_valid_o), 32'h1);
        chk("bp_new_data", rsp_data_o, 32'h0000_000F);
        chk("bp_new_id", 32'(rsp_id_o), 32'h1);

        // Idle: result pops, nobody ready
        step();
        chk("idle_valid", 32'(rsp_valid_o), 32'h0);
        chk("idle_ready0", 32'(req0_ready_o), 32'h0);
        chk("idle_ready1", 32'(req1_ready_o), 32'h0);

        // Reset while stalled; pointer currently favours requester 0, so
        // move it to 1 first to make the restart observable
        set0(1'b1, 2'd2, 32'h8000_0000, 5'd4, 4'h4);
        step();
        req0_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        step();
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid_o), 32'h0);
        chk("async_rst_data", rsp_data_o, 32'h0);
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        #1;
        chk("rst_held_ready0", 32'(req0_ready_o), 32'h0);
        step(); step();
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        step();
        chk("post_rst_id", 32'(rsp_id_o), 32'h0);
        step();
        chk("post_rst_id2", 32'(rsp_id_o), 32'h1);
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
